// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map and column rotation helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_START = 4'b1110;

  // Indexed by {row, col}; row 0 is the top row of the keypad.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clk scan tick every SCAN_DIV clk cycles.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] tick_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == LAST);
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_entry.sv
// 4x4 keypad scanner with debounce and a two-digit entry register.
// Define KEYPAD_HEX_ENTRY_EN to shift A-F into entry; otherwise C clears entry. row_in is sampled only on scan ticks.
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] entry
);

  localparam int SW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_TICKS);

  state_t        state, state_nx;
  logic          tick;
  logic [3:0]    row_lat, row_lat_nx;
  logic [3:0]    col_nx, code_nx, key_sel;
  logic [SW-1:0] stable_cnt, stable_nx, stable_inc;
  logic [7:0]    entry_nx;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  assign key_sel    = KEY_MAP[{low_index(row_lat), low_index(col_out)}];
  assign stable_inc = stable_cnt + SW'(1);
  assign key_valid  = (state == PRESSED);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= SCAN;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      col_out    <= COL_START;
      row_lat    <= 4'hF;
      stable_cnt <= '0;
      key_code   <= 4'h0;
      entry      <= 8'h00;
    end else begin
      col_out    <= col_nx;
      row_lat    <= row_lat_nx;
      stable_cnt <= stable_nx;
      key_code   <= code_nx;
      entry      <= entry_nx;
    end
  end

  // NOTE: every output defaults to its held value first, so no path infers a latch.
  always_comb begin
    state_nx   = state;
    col_nx     = col_out;
    row_lat_nx = row_lat;
    stable_nx  = stable_cnt;
    code_nx    = key_code;
    entry_nx   = entry;

    case (state)
      SCAN: begin
        if (tick) begin
          if (one_low(row_in)) begin
            row_lat_nx = row_in;
            stable_nx  = '0;
            state_nx   = DEBOUNCE;
          end else begin
            col_nx = rotate_col(col_out);
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (row_in == row_lat) begin
            if (stable_inc == STABLE_MAX) begin
              stable_nx = '0;
              state_nx  = PRESSED;
              code_nx   = key_sel;
`ifdef KEYPAD_HEX_ENTRY_EN
              entry_nx  = {entry[3:0], key_sel};
`else
              if (key_sel <= 4'd9)       entry_nx = {entry[3:0], key_sel};
              else if (key_sel == 4'hC)  entry_nx = 8'h00;
`endif
            end else begin
              stable_nx = stable_inc;
            end
          end else begin
            // Bounce or a second row: rescan the same column.
            stable_nx = '0;
            state_nx  = SCAN;
          end
        end
      end

      PRESSED: state_nx = RELEASE;

      RELEASE: begin
        if (tick) begin
          if (row_in == 4'hF) begin
            if (stable_inc == STABLE_MAX) begin
              stable_nx = '0;
              state_nx  = SCAN;
              col_nx    = rotate_col(col_out);
            end else begin
              stable_nx = stable_inc;
            end
          end else begin
            stable_nx = '0;
          end
        end
      end

      default: state_nx = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Randomised bench for keypad_scan_entry: a physical keypad model drives row_in and a tick-level model predicts outputs.
module tb_keypad_scan_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
`ifdef KEYPAD_HEX_ENTRY_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] row_in, col_out, key_code;
  logic       key_valid;
  logic [7:0] entry;
  logic [15:0] pressed = '0;

  int n_tests  = 0;
  int n_fail   = 0;
  int total_kv = 0;
  int kv0      = 0;

  int         m_mode, m_col, m_cnt, m_kv;
  logic [3:0] m_lat, m_code;
  logic [7:0] m_entry;

  int key_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  keypad_scan_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clk       (clk),
    .clr       (clr),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry     (entry)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] keypad_rows(input logic [15:0] mask, input logic [3:0] drive);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mask[i*4+j] && !drive[j]) r[i] = 1'b0;
    return r;
  endfunction

  assign row_in = keypad_rows(pressed, col_out);

  function automatic logic [3:0] drive_of(input int c);
    logic [3:0] d = 4'hF;
    d[c] = 1'b0;
    return d;
  endfunction

  function automatic logic [15:0] key_bit(input int code);
    logic [15:0] m = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (key_tab[i][j] == code) m[i*4+j] = 1'b1;
    return m;
  endfunction

  function automatic int key_col(input int code);
    int c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (key_tab[i][j] == code) c = j;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_col   = 0;
    m_cnt   = 0;
    m_kv    = 0;
    m_lat   = 4'hF;
    m_code  = 4'h0;
    m_entry = 8'h00;
  endtask

  // One scan tick of the keypad rules: detect, debounce, accept, wait for release.
  task automatic model_tick();
    logic [3:0] rows = keypad_rows(pressed, drive_of(m_col));
    int zeros = 0;
    int r = 0;
    int code;
    m_kv = 0;
    for (int i = 0; i < 4; i++) if (!rows[i]) zeros++;
    case (m_mode)
      0: begin
        if (zeros == 1) begin
          m_lat = rows; m_mode = 1; m_cnt = 0;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
      1: begin
        if (rows == m_lat) begin
          m_cnt++;
          if (m_cnt == DEB) begin
            for (int i = 0; i < 4; i++) if (!m_lat[i]) r = i;
            code   = key_tab[r][m_col];
            m_kv   = 1;
            m_code = 4'(code);
            if (code < 10 || HEX) m_entry = {m_entry[3:0], m_code};
            else if (code == 12)  m_entry = 8'h00;
            m_mode = 2; m_cnt = 0;
          end
        end else begin
          m_cnt = 0; m_mode = 0;
        end
      end
      default: begin
        if (rows == 4'hF) begin
          m_cnt++;
          if (m_cnt == DEB) begin
            m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          m_cnt = 0;
        end
      end
    endcase
  endtask

  // Called just before the tick edge; samples on the following SCAN_DIV negedges.
  task automatic do_tick();
    int kv_seen = 0;
    model_tick();
    repeat (SCAN_DIV) begin
      @(negedge clk);
      kv_seen += int'(key_valid);
    end
    total_kv += kv_seen;
    check("key_valid_pulses", 32'(kv_seen), 32'(m_kv));
    check("col_out", 32'(col_out), 32'(drive_of(m_col)));
    check("key_code", 32'(key_code), 32'(m_code));
    check("entry", 32'(entry), 32'(m_entry));
  endtask

  task automatic do_reset();
    pressed = '0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_col_out", 32'(col_out), 32'h0000000E);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_entry", 32'(entry), 32'h0);
    clr = 1'b0;
    model_reset();
    repeat (SCAN_DIV) @(negedge clk);
  endtask

  task automatic wait_col(input int c);
    for (int i = 0; i < 8 && m_col != c; i++) do_tick();
  endtask

  task automatic press_release(input int code);
    pressed = key_bit(code);
    repeat (10) do_tick();
    pressed = '0;
    repeat (8) do_tick();
  endtask

  task automatic random_phase();
    logic [15:0] mask;
    int kind, c, r1, r2, hold, gap;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      mask = '0;
      if (kind < 7) begin
        mask = key_bit($urandom_range(0, 15));
      end else if (kind < 9) begin
        c  = $urandom_range(0, 3);
        r1 = $urandom_range(0, 3);
        r2 = (r1 + 1 + $urandom_range(0, 2)) % 4;
        mask[r1*4+c] = 1'b1;
        mask[r2*4+c] = 1'b1;
      end else begin
        mask = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
      end
      hold = $urandom_range(1, 9);
      repeat (hold) begin
        pressed = ($urandom_range(0, 5) == 0) ? 16'h0000 : mask;
        do_tick();
      end
      pressed = '0;
      gap = $urandom_range(0, 6);
      repeat (gap) do_tick();
    end
    pressed = '0;
    repeat (8) do_tick();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Key 5 held for 10 ticks.
    kv0 = total_kv;
    press_release(5);
    check("key5_pulses", 32'(total_kv - kv0), 32'd1);
    check("key5_code", 32'(key_code), 32'h5);
    check("key5_entry", 32'(entry), 32'h05);

    // Two-digit entry and tens discard.
    press_release(4);
    press_release(2);
    check("entry_42", 32'(entry), 32'h42);
    press_release(7);
    check("entry_27", 32'(entry), 32'h27);

    // Bounce: low 2, high 1, low 5 on an aligned column.
    wait_col(key_col(9));
    kv0 = total_kv;
    pressed = key_bit(9);
    repeat (2) do_tick();
    pressed = '0;
    do_tick();
    check("bounce_early", 32'(total_kv - kv0), 32'd0);
    pressed = key_bit(9);
    repeat (5) do_tick();
    pressed = '0;
    repeat (8) do_tick();
    check("bounce_pulses", 32'(total_kv - kv0), 32'd1);
    check("bounce_code", 32'(key_code), 32'h9);

    // Rows 1 and 2 low together in column 1.
    kv0 = total_kv;
    pressed = key_bit(5) | key_bit(8);
    repeat (10) do_tick();
    pressed = '0;
    repeat (4) do_tick();
    check("multirow_pulses", 32'(total_kv - kv0), 32'd0);

    // Key C with entry 42.
    do_reset();
    press_release(4);
    press_release(2);
    check("pre_c_entry", 32'(entry), 32'h42);
    press_release(12);
    check("c_code", 32'(key_code), 32'hC);
    check("c_entry", 32'(entry), HEX ? 32'h2C : 32'h00);

    // clr two ticks into DEBOUNCE, then a full debounce afterwards.
    press_release(4);
    wait_col(key_col(1));
    kv0 = total_kv;
    pressed = key_bit(1);
    repeat (3) do_tick();
    check("abort_pulses", 32'(total_kv - kv0), 32'd0);
    do_reset();
    kv0 = total_kv;
    pressed = key_bit(1);
    repeat (3) do_tick();
    check("post_rst_partial", 32'(total_kv - kv0), 32'd0);
    do_tick();
    check("post_rst_full", 32'(total_kv - kv0), 32'd1);
    check("post_rst_code", 32'(key_code), 32'h1);
    pressed = '0;
    repeat (8) do_tick();

    random_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
